csa_addsub_pipe: RTL

Parametrised, pipelined carry-select adder/subtractor that replaces the fixed 32-bit combinational carry-select adder in the ALU datapath. The operand width is split into NSEG = WIDTH/SEG segments. One segment is resolved per pipeline stage, using carry-select (dual half-width chains plus a mux) inside each segment. The block adds a subtract mode, a zero flag and valid/ready handshakes on input and output, so it sits between operand fetch and ALU writeback with backpressure.

---
 rtl/alu_pkg.sv | 13 +
 rtl/csa_segment.sv | 27 ++
 rtl/csa_addsub_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: opcode encodings and segment arithmetic.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of pipeline segments (and stages) for a given width/segment size
    function automatic int unsigned num_segments(input int unsigned width,
                                                 input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/csa_segment.sv
// Combinational carry-select segment: ripple lower half, dual-computed upper
// half selected by the lower-half carry.
module csa_segment #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    localparam int unsigned H = SEG / 2;

    logic [H:0] lo;
    logic [H:0] hi0;
    logic [H:0] hi1;

    // Lower ripple chain plus both speculative upper sums, then carry select
    always_comb begin
        lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, ci};
        hi0 = {1'b0, a[SEG-1:H]} + {1'b0, b[SEG-1:H]};
        hi1 = {1'b0, a[SEG-1:H]} + {1'b0, b[SEG-1:H]} + (H+1)'(1);
        s   = {(lo[H] ? hi1[H-1:0] : hi0[H-1:0]), lo[H-1:0]};
        co  = lo[H] ? hi1[H] : hi0[H];
    end

endmodule

// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment resolved per
// stage, valid/ready handshake with a single global stall enable.
module csa_addsub_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned NSEG = num_segments(WIDTH, SEG);

    if (SEG < 2 || (SEG % 2) != 0) begin : g_bad_seg
        $error("csa_addsub_pipe: SEG must be even and >= 2");
    end
    if ((WIDTH % SEG) != 0) begin : g_bad_width
        $error("csa_addsub_pipe: WIDTH must be a multiple of SEG");
    end

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Effective operands: subtract is A + ~B + 1, cin ignored in that mode
    always_comb begin
        b_eff = (sub == OP_ADD) ? data_b : ~data_b;
        c0    = (sub == OP_SUB) ? 1'b1 : cin;
    end

    // Stage k owns segment k; each stage carries resolved low bits upward and
    // the not-yet-consumed operand bits, shifted so the next segment sits at bit 0.
    for (genvar k = 0; k < NSEG; k++) begin : stage_g
        localparam int unsigned LO  = (k + 1) * SEG;
        localparam int unsigned REM = WIDTH - LO;

        logic [SEG-1:0] seg_a, seg_b, seg_s;
        logic           seg_ci, seg_co;
        logic           valid_d, valid_q;
        logic           carry_d, carry_q;
        logic           amsb_d, amsb_q;
        logic           bmsb_d, bmsb_q;
        logic [LO-1:0]  sum_d, sum_q;

        csa_segment #(.SEG(SEG)) u_seg (
            .a  (seg_a),
            .b  (seg_b),
            .ci (seg_ci),
            .s  (seg_s),
            .co (seg_co)
        );

        if (k == 0) begin : src_g
            // First segment consumes the effective operands directly
            always_comb begin
                seg_a   = data_a[SEG-1:0];
                seg_b   = b_eff[SEG-1:0];
                seg_ci  = c0;
                valid_d = in_valid;
                sum_d   = seg_s;
                carry_d = seg_co;
                amsb_d  = data_a[WIDTH-1];
                bmsb_d  = b_eff[WIDTH-1];
            end
        end else begin : src_g
            // Later segments use the previous stage's carry and deskewed bits
            always_comb begin
                seg_a   = stage_g[k-1].ops_g.a_q[SEG-1:0];
                seg_b   = stage_g[k-1].ops_g.b_q[SEG-1:0];
                seg_ci  = stage_g[k-1].carry_q;
                valid_d = stage_g[k-1].valid_q;
                sum_d   = {seg_s, stage_g[k-1].sum_q};
                carry_d = seg_co;
                amsb_d  = stage_g[k-1].amsb_q;
                bmsb_d  = stage_g[k-1].bmsb_q;
            end
        end

        if (REM > 0) begin : ops_g
            logic [REM-1:0] a_d, a_q, b_d, b_q;

            if (k == 0) begin : fill_g
                // Capture the operand bits above segment 0
                always_comb begin
                    a_d = data_a[WIDTH-1:SEG];
                    b_d = b_eff[WIDTH-1:SEG];
                end
            end else begin : fill_g
                // Drop the segment just consumed, keep the rest aligned at bit 0
                always_comb begin
                    a_d = stage_g[k-1].ops_g.a_q[REM+SEG-1:SEG];
                    b_d = stage_g[k-1].ops_g.b_q[REM+SEG-1:SEG];
                end
            end

            // Remaining-operand registers load only with a valid beat
            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall && valid_d) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSEG - 1) begin : out_g
            logic zero_d, zero_q;

            // Zero flag registered alongside the final sum so it is 0 out of reset
            always_comb zero_d = (sum_d == '0);

            // Zero flag register, held with the rest of the output stage
            always_ff @(posedge clock) begin
                if (reset) begin
                    zero_q <= 1'b0;
                end else if (!stall && valid_d) begin
                    zero_q <= zero_d;
                end
            end
        end

        // Stage registers: valid follows the global enable, data loads only
        // with a valid beat so bubbles leave the last results in place
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                amsb_q  <= 1'b0;
                bmsb_q  <= 1'b0;
                sum_q   <= '0;
            end else if (!stall) begin
                valid_q <= valid_d;
                if (valid_d) begin
                    carry_q <= carry_d;
                    amsb_q  <= amsb_d;
                    bmsb_q  <= bmsb_d;
                    sum_q   <= sum_d;
                end
            end
        end
    end

    // Output stage view, overflow derived from the registered sign bits
    always_comb begin
        out_valid = stage_g[NSEG-1].valid_q;
        sum       = stage_g[NSEG-1].sum_q;
        cout      = stage_g[NSEG-1].carry_q;
        zero      = stage_g[NSEG-1].out_g.zero_q;
        ovf       = ( stage_g[NSEG-1].amsb_q &  stage_g[NSEG-1].bmsb_q & ~sum[WIDTH-1]) |
                    (~stage_g[NSEG-1].amsb_q & ~stage_g[NSEG-1].bmsb_q &  sum[WIDTH-1]);
        stall     = out_valid && !out_ready;
        in_ready  = !stall;
    end

endmodule
